if_fetch_ctrl: RTL

- Controller for the instruction-fetch stage. Decides each cycle whether the PC advances, holds, or redirects.
- Drives the fetch stage's IFWrite, Branch/Jump and JumpAddr inputs, plus the IF/ID register write-enable and flush.
- Arbitrates redirect sources: trap, EX-stage branch, ID-stage jump. Sequences load-use stalls and multi-cycle instruction-memory waits.
- Post-reset hold FSM; saturating performance counters.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/sat_counter.sv | 26 ++
 rtl/if_fetch_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the fetch-control slice: redirect encoding (numeric order is
// priority order), FSM states and the default trap vector.
package cpu_pkg;

  typedef enum logic [1:0] {
    RD_NONE   = 2'd0,
    RD_JUMP   = 2'd1,
    RD_BRANCH = 2'd2,
    RD_TRAP   = 2'd3
  } redir_e;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] TRAP_VECTOR_DEF = 32'h0000_0040;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: post-reset hold, redirect arbitration,
// load-use stalls, imem wait sequencing with a pending-redirect register.
module if_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned RESET_HOLD  = 4,
  parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEF,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_use_hazard,
  input  logic             br_taken_ex,
  input  logic [31:0]      br_target_ex,
  input  logic             jump_id,
  input  logic [31:0]      jump_target_id,
  input  logic             trap_req,
  input  logic             imem_ready,
  output logic             IFWrite,
  output logic             Branch,
  output logic             Jump,
  output logic [31:0]      JumpAddr,
  output logic             IFIDWrite,
  output logic             ID_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [3:0] HOLD_INIT = 4'(RESET_HOLD - 1);

  fetch_state_e state_q, state_d;
  logic [3:0]   hold_cnt_q, hold_cnt_d;
  redir_e       pend_type_q, pend_type_d;
  logic [31:0]  pend_tgt_q, pend_tgt_d;

  redir_e       cur_type;
  logic [31:0]  cur_tgt;
  redir_e       eff_type;
  logic [31:0]  eff_tgt;
  logic         stall_inc;
  logic         flush_inc;

  // Same-cycle arbitration; a jump alongside a branch/trap is on the wrong path.
  always_comb begin
    cur_type = RD_NONE;
    cur_tgt  = '0;
    if (trap_req) begin
      cur_type = RD_TRAP;
      cur_tgt  = TRAP_VECTOR;
    end else if (br_taken_ex) begin
      cur_type = RD_BRANCH;
      cur_tgt  = br_target_ex;
    end else if (jump_id) begin
      cur_type = RD_JUMP;
      cur_tgt  = jump_target_id;
    end
  end

  // In WAIT a strictly higher-priority arrival supersedes the pending redirect.
  always_comb begin
    eff_type = pend_type_q;
    eff_tgt  = pend_tgt_q;
    if (cur_type > pend_type_q) begin
      eff_type = cur_type;
      eff_tgt  = cur_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= HOLD_INIT;
      pend_type_q <= RD_NONE;
      pend_tgt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      pend_type_q <= pend_type_d;
      pend_tgt_q  <= pend_tgt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    pend_type_d = pend_type_q;
    pend_tgt_d  = pend_tgt_q;
    unique case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == '0) state_d = ST_RUN;
        else                  hold_cnt_d = hold_cnt_q - 4'd1;
      end
      ST_RUN: begin
        if (!imem_ready && (cur_type != RD_NONE)) begin
          pend_type_d = cur_type;
          pend_tgt_d  = cur_tgt;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_ready) begin
          pend_type_d = RD_NONE;
          pend_tgt_d  = '0;
          state_d     = ST_RUN;
        end else begin
          pend_type_d = eff_type;
          pend_tgt_d  = eff_tgt;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  always_comb begin
    IFWrite   = 1'b0;
    Branch    = 1'b0;
    Jump      = 1'b0;
    JumpAddr  = '0;
    IFIDWrite = 1'b0;
    ID_flush  = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_RUN: begin
          if (!imem_ready) begin
            stall_inc = 1'b1;
          end else if (cur_type != RD_NONE) begin
            IFWrite   = 1'b1;
            IFIDWrite = 1'b1;
            Branch    = (cur_type == RD_BRANCH) || (cur_type == RD_TRAP);
            Jump      = (cur_type == RD_JUMP);
            JumpAddr  = cur_tgt;
            ID_flush  = (cur_type != RD_JUMP);
            flush_inc = 1'b1;
          end else if (ld_use_hazard) begin
            ID_flush  = 1'b1;
            stall_inc = 1'b1;
          end else begin
            IFWrite   = 1'b1;
            IFIDWrite = 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_ready) begin
            IFWrite   = 1'b1;
            IFIDWrite = 1'b1;
            Branch    = (eff_type == RD_BRANCH) || (eff_type == RD_TRAP);
            Jump      = (eff_type == RD_JUMP);
            JumpAddr  = eff_tgt;
            ID_flush  = (eff_type != RD_JUMP);
            flush_inc = 1'b1;
          end else begin
            stall_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .inc (stall_inc),
    .cnt (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (reset),
    .inc (flush_inc),
    .cnt (flush_count)
  );

endmodule
